// File: rtl/bram_pkg.sv
// Shared parameters and FSM encoding for the 512x512 multi-lane BRAM
// (write-side packer, read-side address generator, BRAM wrapper).
package bram_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned LANES = 16;
  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned RW    = DW * LANES;
  localparam int unsigned LW    = $clog2(LANES);

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/bram_row_packer.sv
// Packs a 32-bit word stream into 512-bit BRAM rows, one write per row, and
// holds each completed frame until the read side acknowledges it.
module bram_row_packer
  import bram_pkg::*;
(
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic              s_last,
  output logic              wea,
  output logic [AW-1:0]     addra,
  output logic [RW-1:0]     dina,
  output logic              frame_done,
  output logic [AW:0]       frame_rows,
  output logic              overflow,
  input  logic              frame_ack
);

  state_t          state;
  logic [AW:0]     row_cnt;
  logic [LW-1:0]   lane_idx;
  logic [RW-1:0]   lane_buf;

  logic            accept_c;
  logic            row_end_c;
  logic            last_row_c;
  logic [RW-1:0]   row_data_c;

  assign s_ready  = (state == FILL) & rsta_n;
  assign accept_c = s_valid & s_ready;

  // Held lanes plus the incoming word; lanes above lane_idx are already zero,
  // so a short final row is zero-padded without extra masking.
  always_comb begin
    row_data_c = lane_buf;
    row_data_c[32'(lane_idx) * DW +: DW] = s_data;
  end

  assign row_end_c  = (lane_idx == LW'(LANES - 1)) | s_last;
  assign last_row_c = (row_cnt == (AW + 1)'(DEPTH - 1));

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state      <= FILL;
      row_cnt    <= '0;
      lane_idx   <= '0;
      lane_buf   <= '0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      frame_done <= 1'b0;
      frame_rows <= '0;
      overflow   <= 1'b0;
    end else begin
      wea <= 1'b0;
      case (state)
        FILL: begin
          if (accept_c) begin
            if (row_end_c) begin
              wea      <= 1'b1;
              addra    <= row_cnt[AW-1:0];
              dina     <= row_data_c;
              lane_buf <= '0;
              lane_idx <= '0;
              row_cnt  <= (AW + 1)'(row_cnt + 1'b1);
              if (s_last) begin
                state      <= DONE;
                frame_done <= 1'b1;
                frame_rows <= (AW + 1)'(row_cnt + 1'b1);
                overflow   <= 1'b0;
              end else if (last_row_c) begin
                // Frame cut at full depth: stop before the address could wrap.
                state      <= DONE;
                frame_done <= 1'b1;
                frame_rows <= (AW + 1)'(DEPTH);
                overflow   <= 1'b1;
              end
            end else begin
              lane_buf <= row_data_c;
              lane_idx <= LW'(lane_idx + 1'b1);
            end
          end
        end
        DONE: begin
          if (frame_ack) begin
            state      <= FILL;
            row_cnt    <= '0;
            lane_idx   <= '0;
            addra      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_row_packer.sv
// Scoreboard bench for bram_row_packer: expected row writes are queued as
// words are accepted and compared when the BRAM write port fires.
module tb_bram_row_packer;
  import bram_pkg::*;

  logic              clka;
  logic              rsta_n;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              s_last;
  logic              wea;
  logic [AW-1:0]     addra;
  logic [RW-1:0]     dina;
  logic              frame_done;
  logic [AW:0]       frame_rows;
  logic              overflow;
  logic              frame_ack;

  bram_row_packer dut (
    .clka       (clka),
    .rsta_n     (rsta_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .frame_done (frame_done),
    .frame_rows (frame_rows),
    .overflow   (overflow),
    .frame_ack  (frame_ack)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            wr_cnt   = 0;

  logic [RW-1:0] m_buf;
  int            m_lane;
  int            m_row;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_buf  = '0;
    m_lane = 0;
    m_row  = 0;
  endtask

  // Reference packing: lane slot per word, row pushed on lane 15 or last.
  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    wr_t w;
    m_buf[m_lane*DW +: DW] = d;
    if (m_lane == LANES - 1 || last) begin
      w.addr = AW'(m_row);
      w.data = m_buf;
      exp_q.push_back(w);
      m_buf  = '0;
      m_lane = 0;
      m_row++;
    end else begin
      m_lane++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_word(input logic [DW-1:0] d, input logic last, input int gap);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clka);
      n++;
    end
    if (n >= 100) begin
      check("handshake_timeout", 0, 1);
    end else begin
      model_accept(d, last);
      @(negedge clka);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge clka);
  endtask

  task automatic send_frame(input int n, input int base, input logic with_last, input logic gaps);
    for (int i = 0; i < n; i++)
      send_word(DW'(base + i), with_last && (i == n - 1), gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(negedge clka);
    frame_ack = 1'b0;
    model_clear();
    check("ack_s_ready", RW'(s_ready), RW'(1));
    check("ack_frame_done", RW'(frame_done), RW'(0));
    check("ack_overflow", RW'(overflow), RW'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wea"}, RW'(wea), RW'(0));
    check({tag, "_addra"}, RW'(addra), RW'(0));
    check({tag, "_dina"}, dina, RW'(0));
    check({tag, "_frame_done"}, RW'(frame_done), RW'(0));
    check({tag, "_frame_rows"}, RW'(frame_rows), RW'(0));
    check({tag, "_overflow"}, RW'(overflow), RW'(0));
    check({tag, "_s_ready"}, RW'(s_ready), RW'(0));
  endtask

  // Write-port monitor: every wea cycle must match the next queued row.
  always @(negedge clka) begin
    if (rsta_n && wea) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", RW'(1), RW'(0));
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addra", RW'(addra), RW'(e.addr));
        check("wr_dina", dina, e.data);
      end
    end
  end

  initial begin
    int w0;
    rsta_n    = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    frame_ack = 1'b0;
    model_clear();
    repeat (3) @(negedge clka);
    check_reset_outputs("rst");
    rsta_n = 1'b1;
    @(negedge clka);
    check("post_rst_s_ready", RW'(s_ready), RW'(1));

    // 32 contiguous words 1..32
    w0 = wr_cnt;
    send_frame(32, 1, 1'b1, 1'b0);
    @(negedge clka);
    check("f32_writes", RW'(wr_cnt - w0), RW'(2));
    check("f32_frame_done", RW'(frame_done), RW'(1));
    check("f32_frame_rows", RW'(frame_rows), RW'(2));
    check("f32_overflow", RW'(overflow), RW'(0));

    // stall in DONE with s_valid held high
    w0 = wr_cnt;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clka);
      if (i == 0 || i == 19) check("stall_s_ready", RW'(s_ready), RW'(0));
    end
    s_valid = 1'b0;
    check("stall_no_write", RW'(wr_cnt - w0), RW'(0));
    check("stall_frame_rows", RW'(frame_rows), RW'(2));

    // release, then a full single-row frame at address 0
    pulse_ack();
    w0 = wr_cnt;
    send_frame(16, 32'h100, 1'b1, 1'b0);
    @(negedge clka);
    check("f16_writes", RW'(wr_cnt - w0), RW'(1));
    check("f16_frame_rows", RW'(frame_rows), RW'(1));

    // short frame A1..A5, zero-padded upper lanes
    pulse_ack();
    w0 = wr_cnt;
    send_frame(5, 32'hA1, 1'b1, 1'b0);
    @(negedge clka);
    check("f5_writes", RW'(wr_cnt - w0), RW'(1));
    check("f5_dina_hi_zero", RW'(dina[RW-1:160]), RW'(0));
    check("f5_frame_rows", RW'(frame_rows), RW'(1));
    check("f5_frame_done", RW'(frame_done), RW'(1));

    // overflow: 8192 words without s_last
    pulse_ack();
    w0 = wr_cnt;
    send_frame(8192, 32'h1000, 1'b0, 1'b0);
    @(negedge clka);
    check("ovf_writes", RW'(wr_cnt - w0), RW'(512));
    check("ovf_last_addra", RW'(addra), RW'(511));
    check("ovf_overflow", RW'(overflow), RW'(1));
    check("ovf_frame_rows", RW'(frame_rows), RW'(512));
    check("ovf_frame_done", RW'(frame_done), RW'(1));
    w0 = wr_cnt;
    s_valid = 1'b1;
    s_data  = 32'h0000_3000;
    repeat (4) begin
      @(negedge clka);
      check("ovf_8193_s_ready", RW'(s_ready), RW'(0));
    end
    s_valid = 1'b0;
    check("ovf_8193_no_write", RW'(wr_cnt - w0), RW'(0));

    // 32 words with random s_valid gaps: same rows as the contiguous run
    pulse_ack();
    w0 = wr_cnt;
    send_frame(32, 1, 1'b1, 1'b1);
    @(negedge clka);
    check("gap_writes", RW'(wr_cnt - w0), RW'(2));
    check("gap_last_addra", RW'(addra), RW'(1));
    check("gap_frame_rows", RW'(frame_rows), RW'(2));

    // reset in the middle of a row
    pulse_ack();
    w0 = wr_cnt;
    send_frame(7, 32'h500, 1'b0, 1'b0);
    rsta_n = 1'b0;
    model_clear();
    @(negedge clka);
    check_reset_outputs("mid_rst");
    check("mid_rst_no_write", RW'(wr_cnt - w0), RW'(0));
    rsta_n = 1'b1;
    @(negedge clka);
    w0 = wr_cnt;
    send_frame(16, 32'h700, 1'b1, 1'b0);
    @(negedge clka);
    check("post_rst_writes", RW'(wr_cnt - w0), RW'(1));
    check("post_rst_lane0", RW'(dina[DW-1:0]), RW'(32'h700));
    check("post_rst_frame_rows", RW'(frame_rows), RW'(1));

    check("scoreboard_empty", RW'(exp_q.size()), RW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
